// File: rtl/rs_enc_pkg.sv
// Field, code and bus constants for the systematic RS(255,239) encoder,
// plus elaboration-time GF(2^8) helpers used to build the generator polynomial.
package rs_enc_pkg;

  localparam int SYMB_WIDTH        = 8;
  localparam int POLY              = 285;
  localparam int N_LEN             = 255;
  localparam int K_LEN             = 239;
  localparam int ROOTS_NUM         = N_LEN - K_LEN;
  localparam int BUS_WIDTH_IN_SYMB = 4;
  localparam int FIRST_ROOT        = 1;
  localparam int P_BEATS           = (ROOTS_NUM + BUS_WIDTH_IN_SYMB - 1) / BUS_WIDTH_IN_SYMB;
  localparam int DATA_W            = BUS_WIDTH_IN_SYMB * SYMB_WIDTH;
  localparam int CNT_W             = $clog2(BUS_WIDTH_IN_SYMB + 1);
  localparam int PB_W              = (P_BEATS > 1) ? $clog2(P_BEATS) : 1;
  localparam int LEN_W             = $clog2(K_LEN + BUS_WIDTH_IN_SYMB + 1);
  localparam int RI_W              = (ROOTS_NUM > 1) ? $clog2(ROOTS_NUM) : 1;

  typedef logic [SYMB_WIDTH-1:0] symb_t;
  typedef symb_t [ROOTS_NUM:0]   gpoly_t;
  typedef symb_t [ROOTS_NUM-1:0] rem_t;
  typedef enum logic [0:0] {ST_MSG = 1'b0, ST_PARITY = 1'b1} state_t;

  localparam logic [SYMB_WIDTH:0] POLY_V = POLY[SYMB_WIDTH:0];

  // Shift-and-add multiply; with one constant operand this folds to XOR trees.
  function automatic symb_t gf_mult(input symb_t a, input symb_t b);
    symb_t p;
    symb_t aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < SYMB_WIDTH; i++) begin
      if (b[i]) p = p ^ aa;
      else      p = p;
      if (aa[SYMB_WIDTH-1]) aa = {aa[SYMB_WIDTH-2:0], 1'b0} ^ POLY_V[SYMB_WIDTH-1:0];
      else                  aa = {aa[SYMB_WIDTH-2:0], 1'b0};
    end
    return p;
  endfunction

  function automatic symb_t gf_alpha_pow(input int e);
    symb_t p;
    p = symb_t'(1'b1);
    for (int k = 0; k < e; k++) p = gf_mult(p, symb_t'(2'd2));
    return p;
  endfunction

  // g(x) = prod (x + alpha^(FIRST_ROOT+i)); g[ROOTS_NUM] is the monic leading term.
  function automatic gpoly_t gen_gpoly();
    gpoly_t g;
    symb_t  root;
    g    = '0;
    g[0] = symb_t'(1'b1);
    for (int i = 0; i < ROOTS_NUM; i++) begin
      root = gf_alpha_pow(FIRST_ROOT + i);
      for (int j = ROOTS_NUM; j > 0; j--) g[j] = g[j-1] ^ gf_mult(g[j], root);
      g[0] = gf_mult(g[0], root);
    end
    return g;
  endfunction

endpackage

// File: rtl/rs_enc_if.sv
// Stream bus of the encoder: message input, codeword output and length error flag.
interface rs_enc_if;
  import rs_enc_pkg::*;

  logic              s_tvalid;
  logic              s_tready;
  logic [DATA_W-1:0] s_tdata;
  logic              s_tlast;
  logic [CNT_W-1:0]  s_tsymb_cnt;
  logic              m_tvalid;
  logic              m_tready;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tparity;
  logic              m_tlast;
  logic              err_len;

  // Environment side: produces messages, consumes codewords.
  modport master (
    output s_tvalid, s_tdata, s_tlast, s_tsymb_cnt, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tparity, m_tlast, err_len
  );

  // Encoder side.
  modport slave (
    input  s_tvalid, s_tdata, s_tlast, s_tsymb_cnt, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tparity, m_tlast, err_len
  );

endinterface

// File: rtl/rs_enc_lfsr_step.sv
// Absorbs up to BUS_WIDTH_IN_SYMB message symbols into the parity remainder in one
// combinational pass; lane 0 is absorbed first, masked lanes leave the remainder untouched.
module rs_enc_lfsr_step
  import rs_enc_pkg::*;
(
  input  rem_t                         i_rem,
  input  logic [DATA_W-1:0]            i_data,
  input  logic [BUS_WIDTH_IN_SYMB-1:0] i_mask,
  output rem_t                         o_rem
);

  localparam gpoly_t G = gen_gpoly();

  rem_t  w_r;
  rem_t  w_sh;
  symb_t w_fb;

  // Unrolled LFSR division by g(x), one stage per lane.
  always_comb begin
    w_r  = i_rem;
    w_sh = '0;
    w_fb = '0;
    for (int l = 0; l < BUS_WIDTH_IN_SYMB; l++) begin
      w_fb    = i_data[l*SYMB_WIDTH +: SYMB_WIDTH] ^ w_r[ROOTS_NUM-1];
      w_sh[0] = gf_mult(w_fb, G[0]);
      for (int i = 1; i < ROOTS_NUM; i++) w_sh[i] = w_r[i-1] ^ gf_mult(w_fb, G[i]);
      w_r = i_mask[l] ? w_sh : w_r;
    end
    o_rem = w_r;
  end

endmodule

// File: rtl/rs_enc.sv
// Systematic RS encoder top: forwards message beats through a one-deep output slot,
// then appends the remainder as P_BEATS parity beats.
module rs_enc
  import rs_enc_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  rs_enc_if.slave bus
);

  state_t                       r_state;
  rem_t                         r_rem;
  logic [LEN_W-1:0]             r_len;
  logic [PB_W-1:0]              r_pbeat;
  logic                         r_m_tvalid;
  logic [DATA_W-1:0]            r_m_tdata;
  logic                         r_m_tparity;
  logic                         r_m_tlast;
  logic                         r_err_len;

  logic                         w_load;
  logic                         w_accept;
  logic [CNT_W-1:0]             w_nvalid;
  logic [BUS_WIDTH_IN_SYMB-1:0] w_mask;
  logic [DATA_W-1:0]            w_msg;
  logic [DATA_W-1:0]            w_par;
  logic [LEN_W-1:0]             w_len_sum;
  logic                         w_ovf;
  logic                         w_last_pbeat;
  rem_t                         w_rem_next;
  int                           w_idx;

  assign w_load       = !r_m_tvalid || bus.m_tready;
  assign bus.s_tready = (r_state == ST_MSG) && w_load;
  assign w_accept     = bus.s_tvalid && bus.s_tready;
  assign w_len_sum    = r_len + LEN_W'(w_nvalid);
  // Only the crossing beat flags; the counter saturates once past K_LEN.
  assign w_ovf        = (r_len <= LEN_W'(K_LEN)) && (w_len_sum > LEN_W'(K_LEN));
  assign w_last_pbeat = (r_pbeat == PB_W'(P_BEATS - 1));

  // Valid-lane count, lane mask and zeroed invalid lanes of the incoming beat.
  always_comb begin
    if (bus.s_tlast && (bus.s_tsymb_cnt != '0)) w_nvalid = bus.s_tsymb_cnt;
    else                                        w_nvalid = CNT_W'(BUS_WIDTH_IN_SYMB);
    w_mask = '0;
    w_msg  = '0;
    for (int l = 0; l < BUS_WIDTH_IN_SYMB; l++) begin
      w_mask[l] = (CNT_W'(l) < w_nvalid);
      w_msg[l*SYMB_WIDTH +: SYMB_WIDTH] = w_mask[l] ? bus.s_tdata[l*SYMB_WIDTH +: SYMB_WIDTH] : '0;
    end
  end

  // Parity lanes of the current beat, highest-degree remainder symbol first.
  always_comb begin
    w_par = '0;
    w_idx = 0;
    for (int l = 0; l < BUS_WIDTH_IN_SYMB; l++) begin
      w_idx = ROOTS_NUM - 1 - (int'(r_pbeat) * BUS_WIDTH_IN_SYMB + l);
      if (w_idx >= 0) w_par[l*SYMB_WIDTH +: SYMB_WIDTH] = r_rem[w_idx[RI_W-1:0]];
      else            w_par[l*SYMB_WIDTH +: SYMB_WIDTH] = '0;
    end
  end

  rs_enc_lfsr_step u_step (
    .i_rem  (r_rem),
    .i_data (w_msg),
    .i_mask (w_mask),
    .o_rem  (w_rem_next)
  );

  // Codeword FSM, remainder/length bookkeeping and the registered output slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_MSG;
      r_rem       <= '0;
      r_len       <= '0;
      r_pbeat     <= '0;
      r_m_tvalid  <= 1'b0;
      r_m_tdata   <= '0;
      r_m_tparity <= 1'b0;
      r_m_tlast   <= 1'b0;
      r_err_len   <= 1'b0;
    end else begin
      r_err_len <= w_accept && w_ovf;
      case (r_state)
        ST_MSG: begin
          if (w_accept) begin
            r_m_tvalid  <= 1'b1;
            r_m_tdata   <= w_msg;
            r_m_tparity <= 1'b0;
            r_m_tlast   <= 1'b0;
            r_rem       <= w_rem_next;
            r_len       <= (r_len > LEN_W'(K_LEN)) ? r_len : w_len_sum;
            if (bus.s_tlast) begin
              r_state <= ST_PARITY;
              r_pbeat <= '0;
            end
          end else if (w_load) begin
            r_m_tvalid <= 1'b0;
          end
        end
        ST_PARITY: begin
          if (w_load) begin
            r_m_tvalid  <= 1'b1;
            r_m_tdata   <= w_par;
            r_m_tparity <= 1'b1;
            r_m_tlast   <= w_last_pbeat;
            if (w_last_pbeat) begin
              r_state <= ST_MSG;
              r_rem   <= '0;
              r_len   <= '0;
              r_pbeat <= '0;
            end else begin
              r_pbeat <= r_pbeat + PB_W'(1);
            end
          end
        end
        default: r_state <= ST_MSG;
      endcase
    end
  end

  assign bus.m_tvalid  = r_m_tvalid;
  assign bus.m_tdata   = r_m_tdata;
  assign bus.m_tparity = r_m_tparity;
  assign bus.m_tlast   = r_m_tlast;
  assign bus.err_len   = r_err_len;

endmodule

// File: tb/tb_rs_enc.sv
// Self-checking bench for rs_enc: table of frames plus hand sequences, scoreboarded
// against a long-division RS model built on log/antilog tables, with syndrome checks.
`timescale 1ns/1ps
module tb_rs_enc;
  import rs_enc_pkg::*;

  localparam int W  = BUS_WIDTH_IN_SYMB;
  localparam int SW = SYMB_WIDTH;
  localparam int R  = ROOTS_NUM;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  rs_enc_if bus ();
  rs_enc dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- GF model ----------------
  int gexp [0:511];
  int glog [0:255];
  int gpol [0:R];

  function automatic int mul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gexp[glog[a] + glog[b]];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic finish_up();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [DATA_W-1:0] data;
    logic              par;
    logic              last;
    bit                dc;
    int                nsym;
  } beat_t;
  beat_t exp_q[$];

  int msg  [0:299];
  int cbuf [0:319];
  int cw   [0:299];
  int par_cap [0:R-1];
  int cw_n = 0, par_seen = 0, frames_done = 0, batch_end = 0;
  bit cw_dc = 0;
  int err_cnt = 0, err_cyc = -1, exp_err_cyc = -2, sym_total = 0;
  bit in_par = 0, stall_prev = 0, noidle_en = 0, seen_out = 0;
  int idle_gaps = 0;
  logic [DATA_W+2:0] prev_out;
  int rdy_mode = 0, held_for = -1;

  task automatic push_parity(input int len);
    beat_t e;
    for (int k = 0; k < len + R; k++) cbuf[k] = (k < len) ? msg[k] : 0;
    for (int i = 0; i < len; i++) begin
      int f;
      f = cbuf[i];
      if (f != 0) for (int j = 1; j <= R; j++) cbuf[i+j] ^= mul(f, gpol[R-j]);
    end
    for (int j = 0; j < P_BEATS; j++) begin
      e.data = '0;
      for (int l = 0; l < W; l++)
        if (j*W + l < R) e.data[l*SW +: SW] = cbuf[len + j*W + l][SW-1:0];
      e.par  = 1'b1;
      e.last = (j == P_BEATS - 1);
      e.dc   = (len > K_LEN);
      e.nsym = (R - j*W < W) ? R - j*W : W;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_accept();
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.s_tready) begin
      t++;
      if (t > 2000) begin
        n_cmp++; n_bad++;
        $display("FAIL accept_timeout: s_tready low %0d cycles, expected high", t);
        finish_up();
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int len, input bit keep_valid);
    int nb;
    nb = (len + W - 1) / W;
    sym_total = 0;
    for (int b = 0; b < nb; b++) begin
      logic [DATA_W-1:0] d, dd;
      int nv, prev;
      beat_t e;
      nv = (b == nb - 1) ? len - b*W : W;
      d  = '0;
      dd = '0;
      for (int l = 0; l < W; l++) begin
        d[l*SW +: SW]  = (l < nv) ? msg[b*W + l][SW-1:0] : '0;
        dd[l*SW +: SW] = (l < nv) ? msg[b*W + l][SW-1:0] : SW'($urandom_range(1, 255));
      end
      bus.s_tvalid    = 1'b1;
      bus.s_tdata     = dd;
      bus.s_tlast     = (b == nb - 1);
      bus.s_tsymb_cnt = (b == nb - 1) ? CNT_W'(nv % W) : CNT_W'($urandom_range(0, W));
      wait_accept();
      prev = sym_total;
      sym_total += nv;
      if (prev <= K_LEN && sym_total > K_LEN) exp_err_cyc = cyc;
      e.data = d; e.par = 1'b0; e.last = 1'b0; e.dc = 1'b0; e.nsym = nv;
      exp_q.push_back(e);
    end
    push_parity(len);
    if (!keep_valid) bus.s_tvalid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic check_reset(input string name);
    check({name, "_m_tvalid"},  64'(bus.m_tvalid),  64'd0);
    check({name, "_m_tparity"}, 64'(bus.m_tparity), 64'd0);
    check({name, "_m_tlast"},   64'(bus.m_tlast),   64'd0);
    check({name, "_err_len"},   64'(bus.err_len),   64'd0);
    check({name, "_m_tdata"},   64'(bus.m_tdata),   64'd0);
    check({name, "_s_tready"},  64'(bus.s_tready),  64'd1);
  endtask

  task automatic fill_msg(input int len, input int kind);
    for (int k = 0; k < 300; k++) msg[k] = 0;
    for (int k = 0; k < len; k++)
      case (kind)
        0:       msg[k] = 0;
        1:       msg[k] = $urandom_range(0, 255);
        2:       msg[k] = 255;
        3:       msg[k] = (k == 0) ? 1 : 0;
        default: msg[k] = 0;
      endcase
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.err_len) begin err_cnt++; err_cyc = cyc; end
      if (stall_prev) check("stall_hold", 64'({bus.m_tvalid, bus.m_tparity, bus.m_tlast, bus.m_tdata}), 64'(prev_out));
      stall_prev = bus.m_tvalid && !bus.m_tready;
      prev_out   = {bus.m_tvalid, bus.m_tparity, bus.m_tlast, bus.m_tdata};
      if (in_par) begin
        if (bus.m_tvalid && bus.m_tlast) in_par = 1'b0;
        else check("s_tready_in_parity", 64'(bus.s_tready), 64'd0);
      end
      if (bus.s_tvalid && bus.s_tready && bus.s_tlast) in_par = 1'b1;
      if (noidle_en && seen_out && frames_done < batch_end && !bus.m_tvalid) idle_gaps++;
      if (noidle_en && bus.m_tvalid) seen_out = 1'b1;
      if (bus.m_tvalid && bus.m_tready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_beat: got data=0x%0h par=%0b last=%0b, expected no beat", bus.m_tdata, bus.m_tparity, bus.m_tlast);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if (bus.m_tparity !== e.par || bus.m_tlast !== e.last || (!e.dc && bus.m_tdata !== e.data)) begin
            n_bad++;
            $display("FAIL beat: got data=0x%0h par=%0b last=%0b, expected data=0x%0h par=%0b last=%0b",
                     bus.m_tdata, bus.m_tparity, bus.m_tlast, e.data, e.par, e.last);
          end
          for (int l = 0; l < e.nsym; l++) begin
            cw[cw_n] = int'(bus.m_tdata[l*SW +: SW]);
            cw_n++;
            if (e.par) par_cap[par_seen*W + l] = int'(bus.m_tdata[l*SW +: SW]);
          end
          if (e.par) par_seen++;
          if (e.dc) cw_dc = 1'b1;
          if (e.last) begin
            if (!cw_dc) begin
              int sor;
              sor = 0;
              for (int i = 0; i < R; i++) begin
                int s;
                s = 0;
                for (int k = 0; k < cw_n; k++) s = mul(s, gexp[FIRST_ROOT + i]) ^ cw[k];
                sor |= s;
              end
              check("syndrome_or", 64'(sor), 64'd0);
            end
            cw_n = 0; par_seen = 0; cw_dc = 1'b0;
            frames_done++;
          end
        end
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  // ---------------- downstream ready ----------------
  initial begin
    bus.m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 1 && bus.m_tvalid && bus.m_tparity && par_seen == 2 && held_for != frames_done) begin
        held_for     = frames_done;
        bus.m_tready = 1'b0;
        repeat (4) @(posedge clk);
      end else begin
        bus.m_tready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // ---------------- main sequence ----------------
  typedef struct { int len; int kind; int exp_err; } vec_t;
  vec_t vt [10];

  initial begin
    gexp[0] = 1;
    for (int i = 1; i < 512; i++) begin
      gexp[i] = gexp[i-1] << 1;
      if ((gexp[i] & 256) != 0) gexp[i] ^= POLY;
    end
    glog[0] = 0;
    for (int i = 0; i < 255; i++) glog[gexp[i]] = i;
    for (int j = 0; j <= R; j++) gpol[j] = 0;
    gpol[0] = 1;
    for (int i = 0; i < R; i++) begin
      for (int j = R; j > 0; j--) gpol[j] = gpol[j-1] ^ mul(gpol[j], gexp[FIRST_ROOT + i]);
      gpol[0] = mul(gpol[0], gexp[FIRST_ROOT + i]);
    end

    vt[0] = '{len: 239, kind: 0, exp_err: 0};
    vt[1] = '{len: 1,   kind: 3, exp_err: 0};
    vt[2] = '{len: 239, kind: 1, exp_err: 0};
    vt[3] = '{len: 2,   kind: 1, exp_err: 0};
    vt[4] = '{len: 3,   kind: 2, exp_err: 0};
    vt[5] = '{len: 4,   kind: 1, exp_err: 0};
    vt[6] = '{len: 5,   kind: 1, exp_err: 0};
    vt[7] = '{len: 238, kind: 2, exp_err: 0};
    vt[8] = '{len: 244, kind: 1, exp_err: 1};
    vt[9] = '{len: 239, kind: 1, exp_err: 0};

    bus.s_tvalid = 1'b0; bus.s_tdata = '0; bus.s_tlast = 1'b0; bus.s_tsymb_cnt = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_reset("reset");

    for (int v = 0; v < 10; v++) begin
      fill_msg(vt[v].len, vt[v].kind);
      err_cnt = 0;
      send_frame(vt[v].len, 1'b0);
      wait_drain($sformatf("vec%0d", v));
      check($sformatf("vec%0d_err_pulses", v), 64'(err_cnt), 64'(vt[v].exp_err));
      if (vt[v].exp_err != 0) check($sformatf("vec%0d_err_cycle", v), 64'(err_cyc), 64'(exp_err_cyc));
      if (vt[v].kind == 3)
        for (int k = 0; k < R; k++) check($sformatf("impulse_par%0d", k), 64'(par_cap[k]), 64'(gpol[R-1-k]));
    end

    // 200 back-to-back full frames with constant ready: no idle output cycles.
    idle_gaps = 0; seen_out = 1'b0; batch_end = frames_done + 200; noidle_en = 1'b1;
    err_cnt = 0;
    for (int f = 0; f < 200; f++) begin
      fill_msg(K_LEN, 1);
      send_frame(K_LEN, f != 199);
    end
    wait_drain("batch");
    noidle_en = 1'b0;
    check("batch_idle_gaps", 64'(idle_gaps), 64'd0);
    check("batch_err_pulses", 64'(err_cnt), 64'd0);

    // Random backpressure with a 5-cycle stall on parity beat 2.
    rdy_mode = 1;
    for (int f = 0; f < 3; f++) begin
      fill_msg(K_LEN - f, 1);
      send_frame(K_LEN - f, f != 2);
    end
    wait_drain("backpressure");
    rdy_mode = 0;
    @(posedge clk); #1;

    // Reset for one cycle while parity beat 1 sits in the output slot.
    fill_msg(K_LEN, 1);
    send_frame(K_LEN, 1'b0);
    begin
      int t;
      t = 0;
      while (!(bus.m_tvalid && bus.m_tparity && par_seen == 1) && t < 1000) begin
        @(posedge clk); #1;
        t++;
      end
      check("mid_reset_reached_beat1", 64'(t < 1000), 64'd1);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    cw_n = 0; par_seen = 0; cw_dc = 1'b0; in_par = 1'b0; stall_prev = 1'b0;
    check_reset("mid_reset");
    fill_msg(K_LEN, 1);
    err_cnt = 0;
    send_frame(K_LEN, 1'b0);
    wait_drain("after_reset");
    check("after_reset_err_pulses", 64'(err_cnt), 64'd0);

    finish_up();
  end

endmodule
